// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller: Moore FSM with a per-state cycle timer,
// fed by 2-flop synchronised car sensors.
module traffic_light_ctrl #(
  parameter int CNT_W       = 4,
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 15,
  parameter int YELLOW_TIME = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic [1:0] state
);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  localparam logic [CNT_W-1:0] MIN_T = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_T = CNT_W'(YELLOW_TIME - 1);

  logic             ta_m, ta_s, tb_m, tb_s;
  logic             ta_v, tb_v;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] timer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ta_m <= 1'b0;
      ta_s <= 1'b0;
      tb_m <= 1'b0;
      tb_s <= 1'b0;
    end else begin
      ta_m <= ta;
      ta_s <= ta_m;
      tb_m <= tb;
      tb_s <= tb_m;
    end
  end

  // The FSM reacts at the edge a sensor change lands in ta_s/tb_s, so it
  // evaluates the value being clocked into the second flop.
  assign ta_v = ta_m;
  assign tb_v = tb_m;

  chain_a: assert property (@(posedge clk) disable iff (!reset_n) ta_s == $past(ta_m));
  chain_b: assert property (@(posedge clk) disable iff (!reset_n) tb_s == $past(tb_m));

  always_comb begin
    state_nxt = state;
    case (state)
      S0: if (tb_v && timer >= MIN_T && (!ta_v || timer == MAX_T)) state_nxt = S1;
      S1: if (timer == YEL_T) state_nxt = S2;
      S2: if (ta_v && timer >= MIN_T && (!tb_v || timer == MAX_T)) state_nxt = S3;
      S3: if (timer == YEL_T) state_nxt = S0;
      default: state_nxt = S0;
    endcase
  end

  // Timer restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S0;
      timer <= '0;
    end else if (state_nxt != state) begin
      state <= state_nxt;
      timer <= '0;
    end else if (timer != MAX_T) begin
      timer <= timer + CNT_W'(1);
    end
  end

  always_comb begin
    la = RED;
    lb = RED;
    case (state)
      S0: begin la = GREEN;  lb = RED;    end
      S1: begin la = YELLOW; lb = RED;    end
      S2: begin la = RED;    lb = GREEN;  end
      S3: begin la = RED;    lb = YELLOW; end
      default: begin la = RED; lb = RED; end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: table-driven sensor segments with
// a queue of expected states, plus hand-written reset sequences.
module tb_traffic_light_ctrl;

  logic       clk;
  logic       reset_n;
  logic       ta;
  logic       tb;
  logic [1:0] la;
  logic [1:0] lb;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       ta;
    logic       tb;
    int         n;
    logic [1:0] st;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] exp_q[$];

  traffic_light_ctrl #(
    .CNT_W(4), .MIN_GREEN(5), .MAX_GREEN(15), .YELLOW_TIME(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ta(ta), .tb(tb),
    .la(la), .lb(lb), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [1:0] la_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] lb_of(input logic [1:0] s);
    case (s)
      2'b10:   return 2'b00;
      2'b11:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [1:0] st);
    chk({name, ".state"}, state, st);
    chk({name, ".la"}, la, la_of(st));
    chk({name, ".lb"}, lb, lb_of(st));
  endtask

  // Drive sensors, queue the state expected after the next edge, then compare.
  task automatic step(input logic a, input logic b, input logic [1:0] st, input string name);
    logic [1:0] e;
    ta = a;
    tb = b;
    exp_q.push_back(st);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty actual=%b required=entry", name, state);
    end else begin
      e = exp_q.pop_front();
      check_outputs(name, e);
    end
  endtask

  // Async assert between edges (checked before any edge), release just after an edge.
  task automatic apply_reset(input string name);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_outputs(name, 2'b00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic add(input logic a, input logic b, input int n, input logic [1:0] st);
    vec_t v;
    v.ta = a;
    v.tb = b;
    v.n  = n;
    v.st = st;
    vecs.push_back(v);
  endtask

  initial begin
    reset_n = 1'b1;
    ta = 1'b0;
    tb = 1'b0;

    // Segments from a fresh reset; edge 1 is the first edge after release.
    add(0, 1, 4, 2'b00);   // tb from cycle 0: A green 5 cycles
    add(0, 1, 2, 2'b01);   // yellow exactly 2
    add(0, 1, 10, 2'b10);  // B green holds while A idle
    add(1, 1, 5, 2'b10);   // both waiting: B runs to 15 cycles total
    add(1, 1, 2, 2'b11);
    add(1, 1, 15, 2'b00);  // periodic 15/2/15/2
    add(1, 1, 2, 2'b01);
    add(1, 1, 15, 2'b10);
    add(1, 1, 2, 2'b11);
    add(1, 1, 15, 2'b00);
    add(1, 1, 2, 2'b01);
    add(1, 1, 1, 2'b10);
    add(0, 0, 20, 2'b10);  // no traffic: hold
    add(1, 0, 1, 2'b10);   // ta rises: switch two edges later
    add(1, 0, 2, 2'b11);
    add(1, 0, 11, 2'b00);
    add(0, 1, 1, 2'b00);   // one-cycle tb pulse, ta idle
    add(0, 0, 2, 2'b01);
    add(0, 0, 3, 2'b10);
    add(0, 1, 6, 2'b10);
    add(1, 1, 1, 2'b10);   // one-cycle ta pulse while tb waiting: ignored
    add(0, 1, 1, 2'b10);
    add(0, 1, 5, 2'b10);

    apply_reset("reset_init");

    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 2'b00, $sformatf("a_only_%0d", i));

    apply_reset("reset_table");
    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].n; j++)
        step(vecs[i].ta, vecs[i].tb, vecs[i].st, $sformatf("vec%0d_%0d", i, j));
    end

    // Reset in the middle of yellow, without a clock edge.
    apply_reset("reset_pre_s1");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b00, $sformatf("to_s1_%0d", i));
    step(1'b0, 1'b1, 2'b01, "in_s1");
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs("async_reset_s1", 2'b00);
    @(posedge clk);
    #1;
    check_outputs("reset_held", 2'b00);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b00, $sformatf("post_rst_%0d", i));
    step(1'b0, 1'b1, 2'b01, "post_rst_y0");
    step(1'b0, 1'b1, 2'b01, "post_rst_y1");
    step(1'b0, 1'b1, 2'b10, "post_rst_bg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
